nrisc_multiciclo: RTL

- Parametrised multicycle successor of the single-cycle 8-bit nRisc core: 8-bit instructions, data width and address width set by parameters.
- Single shared memory port for both instruction and data, with a req/ready handshake, so memory latency can be any number of cycles.
- Register bank, ALU, PC and controller all live inside this block; the controller is an FSM.
- Sits between the testbench or system top and a single memory model.

---
 rtl/nrisc_pkg.sv | 35 +++
 rtl/nrisc_regfile.sv | 35 +++
 rtl/nrisc_multiciclo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nrisc_pkg.sv
// Shared definitions for the multicycle nRisc core: opcodes, controller states
// and instruction field positions.
package nrisc_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_LOG  = 3'b001,
      OP_ADDI = 3'b010,
      OP_LW   = 3'b011,
      OP_SW   = 3'b100,
      OP_BEQZ = 3'b101,
      OP_JR   = 3'b110,
      OP_HALT = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam int OP_MSB  = 7;
   localparam int OP_LSB  = 5;
   localparam int RA_MSB  = 4;
   localparam int RA_LSB  = 3;
   localparam int RB_MSB  = 2;
   localparam int RB_LSB  = 1;
   localparam int F_BIT   = 0;
   localparam int IMM_MSB = 2;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/nrisc_regfile.sv
// Four-entry register bank: one synchronous write port and three
// combinational read ports (two operands plus a debug tap).
module nrisc_regfile
   import nrisc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [1:0]        wsel,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        ra_sel,
   input  logic [1:0]        rb_sel,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] regs [4];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wsel] <= wdata;
      end
   end

   assign ra_data  = regs[ra_sel];
   assign rb_data  = regs[rb_sel];
   assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/nrisc_multiciclo.sv
// Multicycle 8-bit-instruction nRisc core with one shared req/ready memory port.
// Memory request outputs are registered and derived from the next controller state.
module nrisc_multiciclo
   import nrisc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   input  logic [1:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NARROW_W = (ADDR_W < DATA_W) ? ADDR_W : DATA_W;

   state_t            state, state_d;
   logic [ADDR_W-1:0] pc, pc_d;
   logic [7:0]        ir;
   logic [DATA_W-1:0] a, b, alu_out, mdr;
   logic [DATA_W-1:0] alu_result, ra_data, rb_data, wb_data;
   logic [ADDR_W-1:0] a_addr, b_addr;
   opcode_t           op;
   logic [1:0]        ra_idx, rb_idx;
   logic              f;
   logic [2:0]        imm3;
   logic              accept;

   function automatic logic signed [DATA_W-1:0] sext_data(input logic [2:0] imm);
      return {{(DATA_W-3){imm[2]}}, imm};
   endfunction

   function automatic logic signed [ADDR_W-1:0] sext_addr(input logic [2:0] imm);
      return {{(ADDR_W-3){imm[2]}}, imm};
   endfunction

   assign op     = opcode_t'(ir[OP_MSB:OP_LSB]);
   assign ra_idx = ir[RA_MSB:RA_LSB];
   assign rb_idx = ir[RB_MSB:RB_LSB];
   assign f      = ir[F_BIT];
   assign imm3   = ir[IMM_MSB:IMM_LSB];
   assign accept = mem_req & mem_ready;

   // Register values used as addresses: truncated or zero-extended to ADDR_W.
   always_comb begin
      a_addr = '0;
      b_addr = '0;
      a_addr[NARROW_W-1:0] = a[NARROW_W-1:0];
      b_addr[NARROW_W-1:0] = b[NARROW_W-1:0];
   end

   always_comb begin
      alu_result = a;
      case (op)
         OP_ADD:  alu_result = f ? (a - b) : (a + b);
         OP_LOG:  alu_result = f ? (a | b) : (a & b);
         OP_ADDI: alu_result = a + sext_data(imm3);
         default: alu_result = a;
      endcase
   end

   always_comb begin
      state_d = state;
      pc_d    = pc;
      case (state)
         S_FETCH: begin
            if (accept) begin
               state_d = S_DECODE;
               pc_d    = pc + 1'b1;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_ADD, OP_LOG, OP_ADDI: state_d = S_WB;
               OP_LW, OP_SW:            state_d = S_MEM;
               OP_BEQZ: begin
                  state_d = S_FETCH;
                  if (a == '0) pc_d = pc + sext_addr(imm3);
               end
               OP_JR: begin
                  state_d = S_FETCH;
                  pc_d    = a_addr;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            if (accept) state_d = (op == OP_SW) ? S_FETCH : S_WB;
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= '0;
         ir        <= '0;
         a         <= '0;
         b         <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         // Port outputs follow the state being entered, so they are held
         // unchanged for every cycle the access waits for ready.
         mem_req   <= (state_d == S_FETCH) || (state_d == S_MEM);
         mem_we    <= (state_d == S_MEM) && (op == OP_SW);
         mem_addr  <= (state_d == S_MEM) ? b_addr : pc_d;
         mem_wdata <= a;
         if (state == S_FETCH && accept) ir <= mem_rdata[7:0];
         if (state == S_DECODE) begin
            a <= ra_data;
            b <= rb_data;
         end
         if (state == S_EXEC) alu_out <= alu_result;
         if (state == S_MEM && accept) mdr <= mem_rdata;
      end
   end

   assign wb_data = (op == OP_LW) ? mdr : alu_out;
   assign halted  = (state == S_HALT);
   assign pc_out  = pc;

   nrisc_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk      (Clock),
      .reset    (reset),
      .we       (state == S_WB),
      .wsel     (ra_idx),
      .wdata    (wb_data),
      .ra_sel   (ra_idx),
      .rb_sel   (rb_idx),
      .dbg_sel  (dbg_sel),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (dbg_data)
   );

endmodule
